// File: rtl/axi_lite_reg_slave_if.sv
// AXI-lite slave-side bundle: AW, W, B, AR and R channels with valid/ready pairs.
// Latency: none; wiring only.
// Backpressure: carried by the *ready / *valid pairs of each channel.
// Ports: master modport drives requests and response readies; slave modport drives
//        request readies and responses.
interface axi_lite_reg_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   s_awaddr;
  logic                    s_awvalid;
  logic                    s_awready;
  logic [DATA_WIDTH-1:0]   s_wdata;
  logic [DATA_WIDTH/8-1:0] s_wstrb;
  logic                    s_wvalid;
  logic                    s_wready;
  logic [1:0]              s_bresp;
  logic                    s_bvalid;
  logic                    s_bready;
  logic [ADDR_WIDTH-1:0]   s_araddr;
  logic                    s_arvalid;
  logic                    s_arready;
  logic [DATA_WIDTH-1:0]   s_rdata;
  logic [1:0]              s_rresp;
  logic                    s_rvalid;
  logic                    s_rready;

  modport master (
    output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
           s_araddr, s_arvalid, s_rready,
    input  s_awready, s_wready, s_bresp, s_bvalid,
           s_arready, s_rdata, s_rresp, s_rvalid
  );

  modport slave (
    input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
           s_araddr, s_arvalid, s_rready,
    output s_awready, s_wready, s_bresp, s_bvalid,
           s_arready, s_rdata, s_rresp, s_rvalid
  );
endinterface

// File: rtl/axi_lite_reg_slave.sv
// AXI-lite register bank slave: AW/W in any order, byte-strobed writes, registered reads.
// Latency: last of AW/W handshake -> B and new register value next cycle; AR -> R next cycle.
// Backpressure: B/R held stable until bready/rready; request readies stay low meanwhile.
// Ports: clk, rst (async, active-high); bus (slave modport, all five channels);
//        regs_o (flat register contents, reg k at [k*DATA_WIDTH +: DATA_WIDTH]);
//        reg_wr_o (one-cycle per-register pulse on each committed in-range write).
module axi_lite_reg_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  axi_lite_reg_slave_if.slave            bus,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            reg_wr_o
);

  localparam int BYTES   = DATA_WIDTH / 8;
  localparam int IDX_LSB = $clog2(BYTES);
  localparam int IDX_W   = $clog2(NUM_REGS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [NUM_REGS-1:0] ONE_HOT_LSB = {{(NUM_REGS-1){1'b0}}, 1'b1};

  typedef logic [IDX_W-1:0] idx_t;

  // Write beat held while waiting for the matching AW.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] dat;
    logic [BYTES-1:0]      strb;
  } wbeat_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_A,
    W_HAVE_D,
    W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } r_state_t;

  // Anything at or above NUM_REGS*BYTES has a nonzero bit above the index field.
  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
    return (a >> (IDX_LSB + IDX_W)) == '0;
  endfunction

  function automatic idx_t addr_idx(input logic [ADDR_WIDTH-1:0] a);
    return a[IDX_LSB +: IDX_W];
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  w_state_t                       w_state;
  r_state_t                       r_state;
  logic                           awready_q;
  logic                           wready_q;
  logic                           bvalid_q;
  logic [1:0]                     bresp_q;
  logic                           arready_q;
  logic                           rvalid_q;
  logic [1:0]                     rresp_q;
  logic [DATA_WIDTH-1:0]          rdata_q;
  logic [ADDR_WIDTH-1:0]          aw_addr_q;
  wbeat_t                         w_beat_q;
  logic [NUM_REGS-1:0]            reg_wr_q;
  logic [NUM_REGS*DATA_WIDTH-1:0] regs_q;

  logic aw_hs;
  logic w_hs;
  logic ar_hs;

  // Readies are registers, so a handshake never depends combinationally on an input
  // reaching an output; they are 1 only in the states that accept that channel.
  assign aw_hs = bus.s_awvalid && awready_q;
  assign w_hs  = bus.s_wvalid  && wready_q;
  assign ar_hs = bus.s_arvalid && arready_q;

  // ---------------------------------------------------------------------------
  // Commit selection: the half of the write that arrives last comes straight
  // from the bus, the earlier half from its capture register.
  // ---------------------------------------------------------------------------
  logic                  commit_vld;
  logic [ADDR_WIDTH-1:0] commit_addr;
  logic [DATA_WIDTH-1:0] commit_dat;
  logic [BYTES-1:0]      commit_strb;
  logic                  commit_ok;
  idx_t                  commit_idx;

  always_comb begin
    commit_vld  = 1'b0;
    commit_addr = bus.s_awaddr;
    commit_dat  = bus.s_wdata;
    commit_strb = bus.s_wstrb;
    case (w_state)
      W_IDLE: begin
        commit_vld = aw_hs && w_hs;
      end
      W_HAVE_A: begin
        commit_vld  = w_hs;
        commit_addr = aw_addr_q;
      end
      W_HAVE_D: begin
        commit_vld  = aw_hs;
        commit_dat  = w_beat_q.dat;
        commit_strb = w_beat_q.strb;
      end
      default: begin
        commit_vld = 1'b0;
      end
    endcase
  end

  assign commit_ok  = addr_in_range(commit_addr);
  assign commit_idx = addr_idx(commit_addr);

  // ---------------------------------------------------------------------------
  // Write FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state   <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      aw_addr_q <= '0;
      w_beat_q  <= '0;
      reg_wr_q  <= '0;
    end else begin
      reg_wr_q <= '0;
      case (w_state)
        W_IDLE: begin
          // Readies come up here on the first edge after reset is released.
          awready_q <= 1'b1;
          wready_q  <= 1'b1;
          if (commit_vld) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= commit_ok ? RESP_OKAY : RESP_SLVERR;
            reg_wr_q  <= commit_ok ? (ONE_HOT_LSB << commit_idx) : '0;
            w_state   <= W_RESP;
          end else if (aw_hs) begin
            aw_addr_q <= bus.s_awaddr;
            awready_q <= 1'b0;
            w_state   <= W_HAVE_A;
          end else if (w_hs) begin
            w_beat_q  <= '{dat: bus.s_wdata, strb: bus.s_wstrb};
            wready_q  <= 1'b0;
            w_state   <= W_HAVE_D;
          end
        end
        W_HAVE_A, W_HAVE_D: begin
          if (commit_vld) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= commit_ok ? RESP_OKAY : RESP_SLVERR;
            reg_wr_q  <= commit_ok ? (ONE_HOT_LSB << commit_idx) : '0;
            w_state   <= W_RESP;
          end
        end
        W_RESP: begin
          if (bus.s_bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            w_state   <= W_IDLE;
          end
        end
        default: begin
          w_state <= W_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Register bank: byte lanes without a strobe keep their old contents.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '0;
    end else if (commit_vld && commit_ok) begin
      for (int b = 0; b < BYTES; b++) begin
        if (commit_strb[b]) begin
          regs_q[int'(commit_idx)*DATA_WIDTH + b*8 +: 8] <= commit_dat[b*8 +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read FSM: data sampled from regs_q at the AR edge, so a write committing on
  // the same edge is not yet visible and the pre-write value is returned.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (ar_hs) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            r_state   <= R_RESP;
            if (addr_in_range(bus.s_araddr)) begin
              rdata_q <= regs_q[int'(addr_idx(bus.s_araddr))*DATA_WIDTH +: DATA_WIDTH];
              rresp_q <= RESP_OKAY;
            end else begin
              rdata_q <= '0;
              rresp_q <= RESP_SLVERR;
            end
          end
        end
        R_RESP: begin
          if (bus.s_rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            r_state   <= R_IDLE;
          end
        end
        default: begin
          r_state <= R_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.s_awready = awready_q;
  assign bus.s_wready  = wready_q;
  assign bus.s_bvalid  = bvalid_q;
  assign bus.s_bresp   = bresp_q;
  assign bus.s_arready = arready_q;
  assign bus.s_rvalid  = rvalid_q;
  assign bus.s_rresp   = rresp_q;
  assign bus.s_rdata   = rdata_q;
  assign regs_o        = regs_q;
  assign reg_wr_o      = reg_wr_q;

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Randomized self-checking bench for axi_lite_reg_slave against an array-based register model.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
// Responses are backpressured for a random number of cycles; the directed cases run first.
module tb_axi_lite_reg_slave;

  logic          clk;
  logic          rst;
  logic [511:0]  regs_o;
  logic [15:0]   reg_wr_o;

  axi_lite_reg_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi_lite_reg_slave #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .NUM_REGS  (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .regs_o   (regs_o),
    .reg_wr_o (reg_wr_o)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] model [16];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] model_flat();
    logic [511:0] v;
    v = '0;
    for (int k = 0; k < 16; k++) v[k*32 +: 32] = model[k];
    return v;
  endfunction

  function automatic bit in_rng(input logic [31:0] a);
    return a < 32'd64;
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) & 32'hF);
  endfunction

  task automatic clear_model();
    for (int k = 0; k < 16; k++) model[k] = 32'h0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awready"}, bus.s_awready, 0);
    check({tag, "_wready"},  bus.s_wready,  0);
    check({tag, "_arready"}, bus.s_arready, 0);
    check({tag, "_bvalid"},  bus.s_bvalid,  0);
    check({tag, "_rvalid"},  bus.s_rvalid,  0);
    check({tag, "_bresp"},   bus.s_bresp,   0);
    check({tag, "_rresp"},   bus.s_rresp,   0);
    check({tag, "_rdata"},   bus.s_rdata,   0);
    check({tag, "_regs"},    regs_o,        0);
    check({tag, "_reg_wr"},  reg_wr_o,      0);
  endtask

  // mode 0: AW and W together; 1: AW first, W after gap; 2: W first, AW after gap.
  // bp: cycles bready is held low once the response is up.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int mode, input int gap, input int bp);
    bit aw_done, w_done, aw_hs, w_hs, inr;
    int cyc, idx;
    inr = in_rng(addr);
    idx = idx_of(addr);
    bus.s_bready  = (bp == 0);
    bus.s_awvalid = (mode != 2);
    bus.s_wvalid  = (mode != 1);
    // Payload of a channel that is not yet valid is junk and must be ignored.
    bus.s_awaddr  = bus.s_awvalid ? addr : $urandom;
    bus.s_wdata   = bus.s_wvalid ? data : $urandom;
    bus.s_wstrb   = bus.s_wvalid ? strb : 4'($urandom);
    aw_done = 0;
    w_done  = 0;
    cyc     = 0;
    while (!(aw_done && w_done) && cyc < 50) begin
      aw_hs = bus.s_awvalid && bus.s_awready;
      w_hs  = bus.s_wvalid && bus.s_wready;
      tick();
      cyc++;
      if (aw_hs) begin
        aw_done = 1;
        bus.s_awvalid = 0;
        bus.s_awaddr  = $urandom;
      end
      if (w_hs) begin
        w_done = 1;
        bus.s_wvalid = 0;
        bus.s_wdata  = $urandom;
        bus.s_wstrb  = 4'($urandom);
      end
      if (!aw_done && !bus.s_awvalid && cyc >= gap) begin
        bus.s_awvalid = 1;
        bus.s_awaddr  = addr;
      end
      if (!w_done && !bus.s_wvalid && cyc >= gap) begin
        bus.s_wvalid = 1;
        bus.s_wdata  = data;
        bus.s_wstrb  = strb;
      end
      if (aw_done != w_done) begin
        check("half_awready", bus.s_awready, !aw_done);
        check("half_wready",  bus.s_wready,  !w_done);
        check("half_bvalid",  bus.s_bvalid,  0);
        check("half_reg_wr",  reg_wr_o,      0);
      end
    end
    check("wr_hs_done", aw_done && w_done, 1);
    if (inr) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
    end
    check("b_valid",  bus.s_bvalid, 1);
    check("b_resp",   bus.s_bresp,  inr ? 2'b00 : 2'b10);
    check("wr_regs",  regs_o,       model_flat());
    check("wr_pulse", reg_wr_o,     inr ? (16'h1 << idx) : 16'h0);
    check("b_awready", bus.s_awready, 0);
    check("b_wready",  bus.s_wready,  0);
    for (int i = 0; i < bp; i++) begin
      tick();
      check("bp_bvalid",  bus.s_bvalid, 1);
      check("bp_bresp",   bus.s_bresp,  inr ? 2'b00 : 2'b10);
      check("bp_reg_wr",  reg_wr_o,     0);
      check("bp_awready", bus.s_awready, 0);
      check("bp_wready",  bus.s_wready,  0);
    end
    bus.s_bready = 1;
    tick();
    check("b_done_bvalid",  bus.s_bvalid,  0);
    check("b_done_awready", bus.s_awready, 1);
    check("b_done_wready",  bus.s_wready,  1);
    check("b_done_reg_wr",  reg_wr_o,      0);
  endtask

  task automatic do_read(input logic [31:0] addr, input int bp);
    int cyc;
    bit inr;
    logic [31:0] exp;
    inr = in_rng(addr);
    bus.s_rready  = (bp == 0);
    bus.s_araddr  = addr;
    bus.s_arvalid = 1;
    cyc = 0;
    while (!bus.s_arready && cyc < 50) begin
      tick();
      cyc++;
    end
    check("ar_ready_seen", bus.s_arready, 1);
    exp = inr ? model[idx_of(addr)] : 32'h0;
    tick();
    bus.s_arvalid = 0;
    bus.s_araddr  = $urandom;
    check("r_valid",   bus.s_rvalid,  1);
    check("r_data",    bus.s_rdata,   exp);
    check("r_resp",    bus.s_rresp,   inr ? 2'b00 : 2'b10);
    check("r_arready", bus.s_arready, 0);
    for (int i = 0; i < bp; i++) begin
      tick();
      check("bp_rvalid",  bus.s_rvalid,  1);
      check("bp_rdata",   bus.s_rdata,   exp);
      check("bp_rresp",   bus.s_rresp,   inr ? 2'b00 : 2'b10);
      check("bp_arready", bus.s_arready, 0);
    end
    bus.s_rready = 1;
    tick();
    check("r_done_rvalid",  bus.s_rvalid,  0);
    check("r_done_arready", bus.s_arready, 1);
  endtask

  initial begin
    logic [31:0] a, d, old;
    rst = 1'b1;
    bus.s_awaddr = '0; bus.s_awvalid = 0; bus.s_wdata = '0; bus.s_wstrb = '0;
    bus.s_wvalid = 0; bus.s_bready = 1; bus.s_araddr = '0; bus.s_arvalid = 0;
    bus.s_rready = 1;
    clear_model();

    // Reset state, and readies rise only on the first edge after release.
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst = 1'b0;
    check("rel_awready_low", bus.s_awready, 0);
    tick();
    check("rel_awready", bus.s_awready, 1);
    check("rel_wready",  bus.s_wready,  1);
    check("rel_arready", bus.s_arready, 1);

    // Directed cases.
    do_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    check("reg1_value", regs_o[1*32 +: 32], 32'hDEADBEEF);
    do_read(32'h04, 0);
    do_write(32'h08, 32'hCAFEF00D, 4'hF, 2, 3, 0);
    check("reg2_value", regs_o[2*32 +: 32], 32'hCAFEF00D);
    do_write(32'h0C, 32'h11223344, 4'hF, 1, 2, 0);
    do_write(32'h0C, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
    check("reg3_partial", regs_o[3*32 +: 32], 32'h11BB33DD);
    do_write(32'h40, 32'h12345678, 4'hF, 0, 0, 0);
    do_read(32'h40, 0);
    do_write(32'h10, 32'h0BADF00D, 4'hF, 0, 0, 5);
    do_read(32'h10, 5);
    do_write(32'h18, 32'h99999999, 4'h0, 0, 0, 0);

    // Same-edge AR and write commit to reg0: the read sees the old value.
    old = model[0];
    check("same_old_zero", old, 32'h0);
    bus.s_awaddr = 32'h0; bus.s_wdata = 32'h5; bus.s_wstrb = 4'hF;
    bus.s_awvalid = 1; bus.s_wvalid = 1; bus.s_araddr = 32'h0; bus.s_arvalid = 1;
    bus.s_bready = 1; bus.s_rready = 1;
    tick();
    bus.s_awvalid = 0; bus.s_wvalid = 0; bus.s_arvalid = 0;
    model[0] = 32'h5;
    check("same_rvalid", bus.s_rvalid, 1);
    check("same_rdata",  bus.s_rdata,  32'h0);
    check("same_bvalid", bus.s_bvalid, 1);
    check("same_regs",   regs_o,       model_flat());
    tick();
    check("same_done_b", bus.s_bvalid, 0);
    check("same_done_r", bus.s_rvalid, 0);
    do_read(32'h0, 0);

    // Randomized traffic.
    for (int it = 0; it < 60; it++) begin
      a = 32'($urandom_range(0, 19)) * 4 + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = $urandom;
      d = $urandom;
      if ($urandom_range(0, 1) == 0)
        do_write(a, d, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 3),
                 $urandom_range(0, 2));
      else
        do_read(a, $urandom_range(0, 2));
    end

    // Reset while AW is held in HAVE_A: nothing commits, everything clears.
    bus.s_awaddr = 32'h14; bus.s_awvalid = 1;
    tick();
    bus.s_awvalid = 0;
    check("hava_awready", bus.s_awready, 0);
    check("hava_wready",  bus.s_wready,  1);
    rst = 1'b1;
    #1;
    clear_model();
    check_reset_outputs("mid_rst");
    tick();
    rst = 1'b0;
    bus.s_wdata = 32'h77777777; bus.s_wstrb = 4'hF;
    tick();
    check("post_rst_awready", bus.s_awready, 1);
    check("post_rst_wready",  bus.s_wready,  1);
    tick();
    check("post_rst_regs",   regs_o,       0);
    check("post_rst_bvalid", bus.s_bvalid, 0);
    do_write(32'h14, 32'h600DCAFE, 4'hF, 1, 1, 0);
    do_read(32'h14, 1);
    do_read(32'h04, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
